// File: rtl/snn_event_scheduler.sv
// snn_event_scheduler: per-event sequencer for the N_PE spiking-neuron array.
// Define SNN_SCHED_LEAK_EN to add the one-cycle LEAK phase and leak_en port.
module snn_event_scheduler #(
    parameter int N_PE   = 16,
    parameter int PE_W   = $clog2(N_PE),
    parameter int MEM_AW = $clog2(N_PE * N_PE)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              event_valid,
    input  logic [PE_W-1:0]   event_addr,
    output logic              event_ready,
    output logic [MEM_AW-1:0] weight_mem_raddr,
    output logic              weight_w_en,
    output logic [PE_W-1:0]   pe_sel,
    output logic              accum_en,
    input  logic [N_PE-1:0]   spike,
    output logic              spike_done,
    output logic [PE_W-1:0]   spike_addr,
    input  logic              out_full,
`ifdef SNN_SCHED_LEAK_EN
    output logic              leak_en,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        SETTLE,
        FIRE
`ifdef SNN_SCHED_LEAK_EN
        , LEAK
`endif
    } state_t;

    localparam logic [PE_W:0]   K_LAST = (PE_W + 1)'(N_PE);
    localparam logic [PE_W-1:0] A_LAST = PE_W'(N_PE - 1);

    state_t            state;
    state_t            state_n;
    logic [PE_W:0]     k;
    logic [PE_W:0]     km1;
    logic [PE_W-1:0]   kaddr;
    logic [MEM_AW-1:0] base;
    logic [N_PE-1:0]   fired;
    logic [N_PE-1:0]   pending;
    logic [N_PE-1:0]   onehot;
    logic [PE_W-1:0]   low;
    logic [PE_W-1:0]   last_addr;
    logic              any;
    logic              issue;

    // Lowest pending PE wins; fired masks PEs that clear their flag late.
    always_comb begin
        pending = spike & ~fired;
        any     = |pending;
        low     = '0;
        for (int i = N_PE - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low = PE_W'(i);
            end
        end
        onehot = N_PE'(1) << low;
        issue  = (state == FIRE) && any && !out_full;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (event_valid) state_n = LOAD;
            LOAD:    if (k == K_LAST) state_n = ACCUM;
            ACCUM:   state_n = SETTLE;
            SETTLE:  state_n = FIRE;
`ifdef SNN_SCHED_LEAK_EN
            FIRE:    if (!any) state_n = LEAK;
            LEAK:    state_n = IDLE;
`else
            FIRE:    if (!any) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            k         <= '0;
            base      <= '0;
            fired     <= '0;
            last_addr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && event_valid) begin
                base <= MEM_AW'(event_addr) << PE_W;
                k    <= '0;
            end
            if (state == LOAD && k != K_LAST) begin
                k <= k + 1'b1;
            end
            if (issue) begin
                fired     <= fired | onehot;
                last_addr <= low;
            end else if (state == FIRE && !any) begin
                fired <= '0;
            end
        end
    end

    // Write strobe trails the read address by one cycle to cover read latency.
    always_comb begin
        km1              = k - 1'b1;
        kaddr            = (k == K_LAST) ? A_LAST : k[PE_W-1:0];
        event_ready      = (state == IDLE);
        busy             = (state != IDLE);
        weight_mem_raddr = '0;
        weight_w_en      = 1'b0;
        pe_sel           = '0;
        if (state == LOAD) begin
            weight_mem_raddr = base + MEM_AW'(kaddr);
            if (k != '0) begin
                weight_w_en = 1'b1;
                pe_sel      = km1[PE_W-1:0];
            end
        end
        accum_en   = (state == ACCUM);
        spike_done = issue;
        spike_addr = issue ? low : last_addr;
`ifdef SNN_SCHED_LEAK_EN
        leak_en    = (state == LEAK);
`endif
    end

endmodule
